// File: rtl/swi_pkg.sv
// Shared defaults and per-channel state type for the switch-bank debouncer.
package swi_pkg;

    localparam int unsigned SWI_NBITS           = 8;
    localparam int unsigned SWI_DEBOUNCE_CYCLES = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } deb_state_t;

endpackage

// File: rtl/swi_debounce_bit.sv
// One switch channel: two-flop synchronizer, persistence counter, debounced
// level with registered rise/fall pulses and a rise-driven toggle latch.
module swi_debounce_bit
    import swi_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = SWI_DEBOUNCE_CYCLES
) (
    input  logic clk_2,
    input  logic reset,
    input  logic swi_raw,
    output logic swi_stable,
    output logic swi_rise,
    output logic swi_fall,
    output logic swi_toggle
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    deb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;
    logic             r_rise;
    logic             r_fall;
    logic             r_toggle;

    deb_state_t       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_stable_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;
    logic             w_toggle_nxt;

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_toggle <= 1'b0;
        end else begin
            r_sync1  <= swi_raw;
            r_sync2  <= r_sync1;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_stable <= w_stable_nxt;
            r_rise   <= w_rise_nxt;
            r_fall   <= w_fall_nxt;
            r_toggle <= w_toggle_nxt;
        end
    end

    // Any edge where the synchronized input matches the accepted level
    // cancels a pending change outright; the count restarts from zero.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_stable_nxt = r_stable;
        w_rise_nxt   = 1'b0;
        w_fall_nxt   = 1'b0;
        w_toggle_nxt = r_toggle;
        if (r_sync2 == r_stable) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
            w_state_nxt  = IDLE;
            w_cnt_nxt    = '0;
            w_stable_nxt = r_sync2;
            w_rise_nxt   = r_sync2;
            w_fall_nxt   = ~r_sync2;
            w_toggle_nxt = r_toggle ^ r_sync2;
        end else begin
            w_state_nxt = PENDING;
            w_cnt_nxt   = r_cnt + 1'b1;
        end
    end

    assign swi_stable = r_stable;
    assign swi_rise   = r_rise;
    assign swi_fall   = r_fall;
    assign swi_toggle = r_toggle;

endmodule

// File: rtl/swi_debouncer.sv
// Switch-bank front end: NBITS independent debounce channels plus a
// combinational any-change flag built from the registered pulses.
module swi_debouncer
    import swi_pkg::*;
#(
    parameter int unsigned NBITS           = SWI_NBITS,
    parameter int unsigned DEBOUNCE_CYCLES = SWI_DEBOUNCE_CYCLES
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic [NBITS-1:0] swi_raw,
    output logic [NBITS-1:0] swi_stable,
    output logic [NBITS-1:0] swi_rise,
    output logic [NBITS-1:0] swi_fall,
    output logic [NBITS-1:0] swi_toggle,
    output logic             any_change
);

    logic [NBITS-1:0] w_rise;
    logic [NBITS-1:0] w_fall;

    for (genvar gi = 0; gi < NBITS; gi++) begin : g_ch
        swi_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk_2      (clk_2),
            .reset      (reset),
            .swi_raw    (swi_raw[gi]),
            .swi_stable (swi_stable[gi]),
            .swi_rise   (w_rise[gi]),
            .swi_fall   (w_fall[gi]),
            .swi_toggle (swi_toggle[gi])
        );
    end

    assign swi_rise   = w_rise;
    assign swi_fall   = w_fall;
    assign any_change = |(w_rise | w_fall);

endmodule
